// File: rtl/ring_monitor.sv
// ring_monitor: checks an 8-bit one-hot ring counter for legal rotate-left
// advance, encodes the hot bit to a phase index, acquires/tracks lock,
// counts revolutions (saturating) and latches a sticky fault code.
// Optional feature macro: RING_MON_HOLD_OK_EN -- when defined, a repeated
// one-hot sample (hold) is legal; when undefined, a hold is a stall fault.
module ring_monitor #(
  parameter int REV_W    = 16,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             init_n,
  input  logic [7:0]       count,
  input  logic             clr_fault,
  output logic [2:0]       phase,
  output logic             phase_vld,
  output logic             locked,
  output logic             rev_tick,
  output logic [REV_W-1:0] rev_count,
  output logic             fault,
  output logic [1:0]       fault_code
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCK_CNT - 1);
  localparam logic [1:0] CODE_NOT_ONEHOT = 2'b01;
  localparam logic [1:0] CODE_JUMP       = 2'b10;
  localparam logic [1:0] CODE_STALL      = 2'b11;

  state_t           state, state_nxt;
  logic [7:0]       count_q;
  logic [3:0]       lock_cnt, lock_cnt_nxt;
  logic             fault_nxt;
  logic [1:0]       fault_code_nxt;
  logic             rev_tick_nxt;
  logic [REV_W-1:0] rev_count_nxt;

  logic             onehot;
  logic             good_step;
  logic             hold;
  logic             hold_legal;
  logic             violation;
  logic [1:0]       viol_code;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // Binary index of the set bit; only meaningful for one-hot inputs.
  function automatic logic [2:0] encode(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Classify the current sample against the previous one.
  always_comb begin
    onehot    = is_onehot(count);
    good_step = onehot && (count == {count_q[6:0], count_q[7]});
    hold      = onehot && (count == count_q);
`ifdef RING_MON_HOLD_OK_EN
    hold_legal = hold;
`else
    hold_legal = 1'b0;
`endif
    violation = !good_step && !hold_legal;
    if (!onehot)   viol_code = CODE_NOT_ONEHOT;
    else if (hold) viol_code = CODE_STALL;
    else           viol_code = CODE_JUMP;
  end

  // Next-state and next-output logic for the lock FSM.
  always_comb begin
    state_nxt      = state;
    lock_cnt_nxt   = lock_cnt;
    fault_nxt      = fault;
    fault_code_nxt = fault_code;
    rev_tick_nxt   = 1'b0;
    rev_count_nxt  = rev_count;
    case (state)
      IDLE: begin
        state_nxt    = ACQ;
        lock_cnt_nxt = 4'd0;
      end
      ACQ: begin
        if (good_step) begin
          if (lock_cnt == LOCK_LAST) begin
            state_nxt    = TRACK;
            lock_cnt_nxt = 4'd0;
          end else begin
            lock_cnt_nxt = lock_cnt + 4'd1;
          end
        end else if (violation) begin
          lock_cnt_nxt = 4'd0;
        end
      end
      TRACK: begin
        if (violation) begin
          state_nxt      = FAULT;
          fault_nxt      = 1'b1;
          fault_code_nxt = viol_code;
        end else if (good_step && count_q[7]) begin
          rev_tick_nxt = 1'b1;
          if (rev_count != {REV_W{1'b1}}) rev_count_nxt = rev_count + REV_W'(1);
        end
      end
      FAULT: begin
        // A simultaneous violation is irrelevant here: clearing wins.
        if (clr_fault) begin
          state_nxt      = ACQ;
          lock_cnt_nxt   = 4'd0;
          fault_nxt      = 1'b0;
          fault_code_nxt = 2'b00;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      state      <= IDLE;
      count_q    <= 8'd0;
      lock_cnt   <= 4'd0;
      locked     <= 1'b0;
      rev_tick   <= 1'b0;
      rev_count  <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      state      <= state_nxt;
      count_q    <= count;
      lock_cnt   <= lock_cnt_nxt;
      locked     <= (state_nxt == TRACK);
      rev_tick   <= rev_tick_nxt;
      rev_count  <= rev_count_nxt;
      fault      <= fault_nxt;
      fault_code <= fault_code_nxt;
    end
  end

  // Phase index follows every one-hot sample; holds on a bad sample.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      phase     <= 3'd0;
      phase_vld <= 1'b0;
    end else begin
      phase_vld <= onehot;
      if (onehot) phase <= encode(count);
    end
  end

endmodule

// File: tb/tb_ring_monitor.sv
// Scoreboard bench for ring_monitor: a behavioural model predicts each
// cycle's outputs into a queue; a monitor pops and compares after each edge.
module tb_ring_monitor;

  localparam int REV_W    = 2;
  localparam int LOCK_CNT = 4;
`ifdef RING_MON_HOLD_OK_EN
  localparam bit HOLD_OK = 1'b1;
`else
  localparam bit HOLD_OK = 1'b0;
`endif

  logic             clk;
  logic             init_n;
  logic [7:0]       count;
  logic             clr_fault;
  logic [2:0]       phase;
  logic             phase_vld;
  logic             locked;
  logic             rev_tick;
  logic [REV_W-1:0] rev_count;
  logic             fault;
  logic [1:0]       fault_code;

  ring_monitor #(.REV_W(REV_W), .LOCK_CNT(LOCK_CNT)) dut (
    .clk(clk), .init_n(init_n), .count(count), .clr_fault(clr_fault),
    .phase(phase), .phase_vld(phase_vld), .locked(locked), .rev_tick(rev_tick),
    .rev_count(rev_count), .fault(fault), .fault_code(fault_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ph; int pv; int lk; int tk; int rc; int ft; int fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model: history of the ring plus a few status facts.
  bit         m_started;
  int         m_streak;
  bit         m_locked;
  bit         m_faulted;
  int         m_code;
  int         m_revs;
  int         m_phase;
  bit         m_pv;
  logic [7:0] m_prev;
  localparam int REV_MAX = (1 << REV_W) - 1;

  function automatic void model(input logic [7:0] c, input bit clr, input bit rn,
                                output exp_t e);
    bit oh, step, hold, viol, tick;
    int kind;
    tick = 0;
    if (!rn) begin
      m_started = 0; m_streak = 0; m_locked = 0; m_faulted = 0;
      m_code = 0; m_revs = 0; m_phase = 0; m_pv = 0; m_prev = 8'h00;
    end else begin
      oh   = ($countones(c) == 1);
      step = oh && (c == {m_prev[6:0], m_prev[7]});
      hold = oh && (c == m_prev);
      viol = !step && !(hold && HOLD_OK);
      kind = !oh ? 1 : (hold ? 3 : 2);
      if (!m_started) begin
        m_started = 1;
        m_streak  = 0;
      end else if (m_faulted) begin
        if (clr) begin m_faulted = 0; m_code = 0; m_streak = 0; end
      end else if (m_locked) begin
        if (viol) begin
          m_locked = 0; m_faulted = 1; m_code = kind;
        end else if (step && m_prev[7]) begin
          tick = 1;
          if (m_revs < REV_MAX) m_revs++;
        end
      end else begin
        if (step) begin
          m_streak++;
          if (m_streak >= LOCK_CNT) begin m_locked = 1; m_streak = 0; end
        end else if (viol) begin
          m_streak = 0;
        end
      end
      if (oh) begin
        m_pv = 1;
        for (int i = 0; i < 8; i++) if (c[i]) m_phase = i;
      end else begin
        m_pv = 0;
      end
      m_prev = c;
    end
    e.ph = m_phase; e.pv = m_pv; e.lk = m_locked; e.tk = tick;
    e.rc = m_revs;  e.ft = m_faulted; e.fc = m_code;
  endfunction

  task automatic drive(input logic [7:0] c, input bit clr, input bit rn);
    exp_t e;
    @(negedge clk);
    count = c; clr_fault = clr; init_n = rn;
    model(c, clr, rn, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: compare every registered output one step after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("phase",      int'(phase),      e.ph);
        chk("phase_vld",  int'(phase_vld),  e.pv);
        chk("locked",     int'(locked),     e.lk);
        chk("rev_tick",   int'(rev_tick),   e.tk);
        chk("rev_count",  int'(rev_count),  e.rc);
        chk("fault",      int'(fault),      e.ft);
        chk("fault_code", int'(fault_code), e.fc);
      end
    end
  end

  logic [7:0] last;
  logic [7:0] seq_a [] = '{8'h01, 8'h02, 8'h04, 8'h0C, 8'h40, 8'h80, 8'h01,
                           8'h02, 8'h04, 8'h20, 8'h03, 8'h04, 8'h08, 8'h10,
                           8'h20, 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08,
                           8'h08, 8'h08, 8'h08};
  bit         clr_a [] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0,
                           0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

  // Stimulus: directed test-plan sequences, then randomized traffic.
  initial begin
    int r, waited;
    init_n = 1'b0; count = 8'h01; clr_fault = 1'b1;
    drive(8'h01, 1, 0);
    drive(8'h01, 1, 0);
    // Acquire lock and run five revolutions (saturating counter).
    last = 8'h01;
    drive(last, 0, 1);
    for (int i = 0; i < 44; i++) begin
      last = {last[6:0], last[7]};
      drive(last, 0, 1);
    end
    // Bad sample, jump, clear race, relock and holds.
    for (int i = 0; i < seq_a.size(); i++) drive(seq_a[i], clr_a[i], 1);
    last = 8'h08;
    drive(last, 1, 1);
    // Randomized traffic, mostly legal rotation with injected errors.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 80)      last = {last[6:0], last[7]};
      else if (r < 87) last = last;
      else if (r < 92) last = 8'($urandom_range(0, 255));
      else             last = 8'h01 << $urandom_range(0, 7);
      drive(last, ($urandom_range(0, 4) == 0), ($urandom_range(0, 199) != 0));
    end
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
